legv8_hazard_scoreboard: RTL and testbench
==========================================

Name: legv8_hazard_scoreboard

Overview:
- Tracks outstanding register writes between decode and writeback in the LEGv8 pipeline.
- Stalls decode when a source register has a pending write.
- Blocks issue when a destination's outstanding-write counter is saturated.
- After a pipeline flush, clears all tracking and holds decode for a fixed drain window.
- Sits beside the decode stage. It consumes the two read-register addresses (second address already muxed by reg2loc) and the writeback write-enable and address.

Parameters:
- REG_COUNT, 32, number of architectural registers.
- ADDR_W, 5, register address width, equal to clog2(REG_COUNT).
- CNT_W, 2, width of each per-register outstanding-write counter; saturates at 2^CNT_W-1.
- ZERO_REG, 31, register index that never creates a hazard (XZR).
- DRAIN_CYCLES, 3, cycles decode is held after a flush.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- issue_valid  in  1  decode holds a valid instruction.
- src1_addr  in  ADDR_W  first read register (instruction[9:5]).
- src1_used  in  1  instruction reads src1.
- src2_addr  in  ADDR_W  second read register (reg2loc-selected).
- src2_used  in  1  instruction reads src2.
- dst_write  in  1  instruction will write a register (regwrite).
- dst_addr  in  ADDR_W  destination register (instruction[4:0]).
- wb_valid  in  1  writeback stage commits a write this cycle.
- wb_addr  in  ADDR_W  writeback destination.
- flush  in  1  kill all in-flight younger instructions.
- stall  out  1  hold the decode and fetch registers this cycle.
- issue_fire  out  1  instruction accepted, equal to issue_valid & ~stall.
- busy  out  1  any counter non-zero.
- stall_count  out  16  saturating count of cycles with issue_valid & stall.

Behaviour:
- Reset (async, rst=1):
  - All counters 0, FSM=RUN, stall_count=0.
  - stall=0, issue_fire=0, busy=0.
- Counters: cnt[r] for r in 0..REG_COUNT-1. cnt[ZERO_REG] is held at 0; issues and writebacks to it are ignored.
- wb_clear(r) = wb_valid & wb_addr==r & r!=ZERO_REG.
- Source hazard for src s: s_used & s!=ZERO_REG & (cnt[s] - wb_clear(s)) != 0.
  - A same-cycle writeback resolves a single pending write, because the regfile writes on the low phase before the read phase.
- Destination block: dst_write & dst_addr!=ZERO_REG & cnt[dst_addr]==max & ~wb_clear(dst_addr).
- stall (combinational) = issue_valid & (state!=RUN | hazard1 | hazard2 | dst_block).
- Counter update on the rising edge, state RUN:
  - If issue_fire & dst_write & dst_addr!=ZERO_REG, increment cnt[dst_addr].
  - If wb_clear(r), decrement cnt[r].
  - Both on the same register leaves the counter unchanged.
  - A decrement at 0 is an illegal writeback: the counter stays 0. The bench flags it as an assertion failure; the RTL does not wrap.
- FSM:
  - RUN -> DRAIN on flush. On that edge all counters clear to 0, and drain_ctr is loaded with DRAIN_CYCLES-1.
  - DRAIN:
    - stall=1 whenever issue_valid.
    - Counters are held at 0; wb_valid is ignored because drained instructions were killed.
    - drain_ctr decrements each cycle; when it reaches 0, go to RUN.
  - flush asserted in DRAIN reloads drain_ctr.
  - flush has priority over issue in the same cycle: no increment and issue_fire=0. issue_fire is therefore gated by ~flush.
- stall_count increments on each cycle with issue_valid & stall and saturates at 16'hFFFF. It is cleared only by rst.
- busy = OR of all counters (registered state, not the next-state value).
- rst asserted mid-DRAIN or mid-hazard returns everything to the reset values immediately.

Test Plan:
1. RAW stall:
   - Issue dst=3, then next cycle src1=3 with no writeback -> stall=1 that cycle, cnt[3]=1.
   - Drive wb_valid, wb_addr=3 -> stall=0 in the same cycle, issue_fire=1, cnt[3]=0 after the edge.
2. XZR:
   - Issue dst=31 with src1=31 and src2=31 repeatedly -> stall never asserts, busy stays 0.
3. Saturation:
   - Issue dst=5 three times with no writeback -> cnt[5]=3.
   - Fourth issue dst=5 -> stall=1.
   - Same cycle with wb_addr=5 -> fire=1, cnt[5] stays 3.
4. Simultaneous issue and writeback:
   - cnt[7]=1; issue dst=7 with wb_addr=7 in the same cycle -> cnt[7]=1, no stall.
5. Flush:
   - cnt[2]=1 and cnt[9]=2; assert flush with issue_valid=1 -> issue_fire=0.
   - Next 3 cycles stall=1 and busy=0.
   - Cycle 4 is RUN; src1=2 issues without stall.
   - stall_count increases by 4: the flush cycle plus 3 drain cycles.
6. Async reset:
   - Assert rst between clock edges during DRAIN -> stall=0, busy=0, stall_count=0 immediately.
   - First post-reset issue fires.

Source files
------------

// File: rtl/legv8_hazard_scoreboard.sv
// Decode-side hazard scoreboard for the LEGv8 pipeline: per-register outstanding-write
// counters, RAW stall, destination saturation block and a post-flush drain window.
module legv8_hazard_scoreboard #(
    parameter int REG_COUNT    = 32,
    parameter int ADDR_W       = 5,
    parameter int CNT_W        = 2,
    parameter int ZERO_REG     = 31,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic              src1_used,
    input  logic [ADDR_W-1:0] src2_addr,
    input  logic              src2_used,
    input  logic              dst_write,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              flush,
    output logic              stall,
    output logic              issue_fire,
    output logic              busy,
    output logic [15:0]       stall_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(ZERO_REG);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t             state;
    logic [DRAIN_W-1:0] drain_ctr;
    logic [CNT_W-1:0]   cnt_q [REG_COUNT];
    logic [REG_COUNT-1:0] wb_clr;
    logic               hazard1;
    logic               hazard2;
    logic               dst_block;

    // NOTE: every signal written in always_comb gets a default first, so no latch can form.
    always_comb begin
        wb_clr = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
            wb_clr[r] = wb_valid && (wb_addr == ADDR_W'(r)) && (r != ZERO_REG);
        end
    end

    // A same-cycle writeback retires one pending write before the register read.
    assign hazard1 = src1_used && (src1_addr != ZERO_ADDR) &&
                     ((cnt_q[src1_addr] - CNT_W'(wb_clr[src1_addr])) != '0);
    assign hazard2 = src2_used && (src2_addr != ZERO_ADDR) &&
                     ((cnt_q[src2_addr] - CNT_W'(wb_clr[src2_addr])) != '0);
    assign dst_block = dst_write && (dst_addr != ZERO_ADDR) &&
                       (cnt_q[dst_addr] == CNT_MAX) && !wb_clr[dst_addr];

    assign stall      = !rst && issue_valid &&
                        ((state != RUN) || hazard1 || hazard2 || dst_block);
    assign issue_fire = !rst && issue_valid && !stall && !flush;

    always_comb begin
        busy = 1'b0;
        for (int r = 0; r < REG_COUNT; r++) begin
            busy = busy | (cnt_q[r] != '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            drain_ctr   <= '0;
            stall_count <= '0;
            // NOTE: the counters are reset explicitly; stale counts would stall decode forever.
            for (int r = 0; r < REG_COUNT; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            if (issue_valid && stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end

            case (state)
                RUN: begin
                    if (flush) begin
                        state     <= DRAIN;
                        drain_ctr <= DRAIN_LOAD;
                        for (int r = 0; r < REG_COUNT; r++) begin
                            cnt_q[r] <= '0;
                        end
                    end else begin
                        for (int r = 0; r < REG_COUNT; r++) begin
                            if (r != ZERO_REG) begin
                                if (issue_fire && dst_write && (dst_addr == ADDR_W'(r)) && !wb_clr[r]) begin
                                    if (cnt_q[r] != CNT_MAX) cnt_q[r] <= cnt_q[r] + CNT_W'(1);
                                end else if (wb_clr[r] &&
                                             !(issue_fire && dst_write && (dst_addr == ADDR_W'(r)))) begin
                                    // Writeback with nothing outstanding is illegal; never wrap.
                                    if (cnt_q[r] != '0) cnt_q[r] <= cnt_q[r] - CNT_W'(1);
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    for (int r = 0; r < REG_COUNT; r++) begin
                        cnt_q[r] <= '0;
                    end
                    if (flush) begin
                        drain_ctr <= DRAIN_LOAD;
                    end else if (drain_ctr == '0) begin
                        state <= RUN;
                    end else begin
                        drain_ctr <= drain_ctr - DRAIN_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_hazard_scoreboard.sv
// Directed bench for legv8_hazard_scoreboard: RAW stall, XZR, saturation, same-cycle
// issue/writeback, flush drain and asynchronous reset, with hand-computed expectations.
module tb_legv8_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  src1_addr;
    logic        src1_used;
    logic [4:0]  src2_addr;
    logic        src2_used;
    logic        dst_write;
    logic [4:0]  dst_addr;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;
    logic        stall;
    logic        issue_fire;
    logic        busy;
    logic [15:0] stall_count;

    int n_vec;
    int n_err;

    legv8_hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .src1_addr   (src1_addr),
        .src1_used   (src1_used),
        .src2_addr   (src2_addr),
        .src2_used   (src2_used),
        .dst_write   (dst_write),
        .dst_addr    (dst_addr),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .flush       (flush),
        .stall       (stall),
        .issue_fire  (issue_fire),
        .busy        (busy),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic iv,
                         input logic [4:0] s1, input logic s1u,
                         input logic [4:0] s2, input logic s2u,
                         input logic dw, input logic [4:0] d,
                         input logic wv, input logic [4:0] wa,
                         input logic fl);
        issue_valid = iv;
        src1_addr   = s1;
        src1_used   = s1u;
        src2_addr   = s2;
        src2_used   = s2u;
        dst_write   = dw;
        dst_addr    = d;
        wb_valid    = wv;
        wb_addr     = wa;
        flush       = fl;
    endtask

    // Checks the combinational outputs 1 ns after the inputs settle, then crosses the edge.
    task automatic cyc(input string tag, input logic exp_stall, input logic exp_fire);
        #1;
        check({tag, ".stall"}, 32'(stall), 32'(exp_stall));
        check({tag, ".fire"},  32'(issue_fire), 32'(exp_fire));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wb(input logic [4:0] wa);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 1, wa, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 5'd1, 0, 0, 0);
        #2;
        check("rst.stall", 32'(stall), 0);
        check("rst.fire", 32'(issue_fire), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.stall_count", 32'(stall_count), 0);

        // RAW stall and same-cycle writeback resolve
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 1, 5'd3, 0, 0, 0);
        cyc("raw.issue", 0, 1);
        check("raw.cnt3a", 32'(dut.cnt_q[3]), 1);
        check("raw.busy", 32'(busy), 1);
        @(negedge clk);
        drive(1, 5'd3, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("raw.hazard", 1, 0);
        check("raw.cnt3b", 32'(dut.cnt_q[3]), 1);
        check("raw.sc", 32'(stall_count), 1);
        @(negedge clk);
        drive(1, 5'd3, 1, 0, 0, 0, 0, 1, 5'd3, 0);
        cyc("raw.wb", 0, 1);
        check("raw.cnt3c", 32'(dut.cnt_q[3]), 0);
        check("raw.busy0", 32'(busy), 0);

        // XZR never creates a hazard or a count
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 5'd31, 1, 5'd31, 1, 1, 5'd31, 0, 0, 0);
            cyc("xzr", 0, 1);
            check("xzr.busy", 32'(busy), 0);
        end
        check("xzr.cnt31", 32'(dut.cnt_q[31]), 0);

        // Saturation on r5
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0);
            cyc("sat.fill", 0, 1);
        end
        check("sat.cnt5", 32'(dut.cnt_q[5]), 3);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0);
        cyc("sat.block", 1, 0);
        check("sat.sc", 32'(stall_count), 2);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd5, 1, 5'd5, 0);
        cyc("sat.wbfire", 0, 1);
        check("sat.cnt5b", 32'(dut.cnt_q[5]), 3);
        // One writeback leaves two pending writes, so a reader still stalls
        @(negedge clk);
        drive(1, 0, 0, 5'd5, 1, 0, 0, 1, 5'd5, 0);
        cyc("sat.src2", 1, 0);
        check("sat.cnt5c", 32'(dut.cnt_q[5]), 2);
        check("sat.sc2", 32'(stall_count), 3);
        idle_wb(5'd5);
        idle_wb(5'd5);
        check("sat.cnt5d", 32'(dut.cnt_q[5]), 0);
        check("sat.busy", 32'(busy), 0);

        // Simultaneous issue and writeback on r7
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0);
        cyc("sim.first", 0, 1);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd7, 1, 5'd7, 0);
        cyc("sim.both", 0, 1);
        check("sim.cnt7", 32'(dut.cnt_q[7]), 1);
        idle_wb(5'd7);
        check("sim.cnt7b", 32'(dut.cnt_q[7]), 0);

        // Flush with drain window
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd2, 0, 0, 0);
        cyc("fl.r2", 0, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1, 0, 0, 0, 0, 1, 5'd9, 0, 0, 0);
            cyc("fl.r9", 0, 1);
        end
        check("fl.cnt9", 32'(dut.cnt_q[9]), 2);
        @(negedge clk);
        drive(1, 5'd2, 1, 0, 0, 0, 0, 0, 0, 1);
        cyc("fl.flush", 1, 0);
        check("fl.sc_flush", 32'(stall_count), 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 5'd2, 1, 0, 0, 0, 0, 1, 5'd9, 0);
            #1;
            check("fl.drain_busy", 32'(busy), 0);
            cyc("fl.drain", 1, 0);
            check("fl.cnt9_drain", 32'(dut.cnt_q[9]), 0);
        end
        check("fl.sc", 32'(stall_count), 7);
        @(negedge clk);
        drive(1, 5'd2, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("fl.run", 0, 1);
        check("fl.sc_after", 32'(stall_count), 7);

        // Flush without hazard: no stall, but the instruction must not fire
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd4, 0, 0, 1);
        cyc("rs.flush", 0, 0);
        check("rs.cnt4", 32'(dut.cnt_q[4]), 0);
        // Async reset mid-DRAIN
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rs.drain_stall", 32'(stall), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rs.stall", 32'(stall), 0);
        check("rs.busy", 32'(busy), 0);
        check("rs.sc", 32'(stall_count), 0);
        check("rs.fire", 32'(issue_fire), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 1, 5'd4, 0, 0, 0);
        cyc("rs.post", 0, 1);
        check("rs.cnt4b", 32'(dut.cnt_q[4]), 1);
        check("rs.busy1", 32'(busy), 1);
        check("rs.sc_post", 32'(stall_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
